// File: rtl/rvc_asap_pkg.sv
// Shared types for the rvc_asap data-memory path: arbitration state,
// requester identity and the per-port memory request bundle.
package rvc_asap_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } t_arb_state;

    // Encoding doubles as the bit index into the 2-bit request/grant vectors.
    typedef enum logic {
        CORE = 1'b0,
        HOST = 1'b1
    } t_arb_owner;

    typedef struct packed {
        logic        wr_en;
        logic [31:0] addr;
        logic [31:0] wr_data;
        logic [3:0]  byte_en;
    } t_mem_req;

endpackage

// File: rtl/rvc_asap_mem_arb_rr.sv
// Two-way round-robin picker: a lone requester wins, a contest goes to the
// port that did not win the previous contest. Bit 0 = core, bit 1 = host.
module rvc_asap_mem_arb_rr (
    input  logic [1:0] i_req,
    input  logic       i_last_winner,
    output logic [1:0] o_gnt
);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pick
            assign o_gnt[gi] = i_req[gi] & (~i_req[1-gi] | (i_last_winner != 1'(gi)));
        end
    endgenerate

endmodule

// File: rtl/rvc_asap_mem_arb.sv
// Shares one synchronous-read data memory between the core load/store path and
// the host loader/debug port, with round-robin fairness and a bounded host lock.
module rvc_asap_mem_arb
    import rvc_asap_pkg::*;
#(
    parameter int          ADDR_W         = 32,
    parameter logic [31:0] MEM_BASE       = 32'h0000_1000,
    parameter int          MEM_DEPTH      = 1024,
    parameter int          MAX_HOST_BURST = 8
) (
    input  logic                         i_clock,
    input  logic                         i_rst,
    input  logic                         i_core_req,
    input  logic                         i_core_wr_en,
    input  logic [ADDR_W-1:0]            i_core_addr,
    input  logic [31:0]                  i_core_wr_data,
    input  logic [3:0]                   i_core_byte_en,
    output logic                         o_core_gnt,
    output logic                         o_core_stall,
    output logic                         o_core_rd_valid,
    output logic [31:0]                  o_core_rd_data,
    output logic                         o_core_err,
    input  logic                         i_host_req,
    input  logic                         i_host_wr_en,
    input  logic [ADDR_W-1:0]            i_host_addr,
    input  logic [31:0]                  i_host_wr_data,
    input  logic [3:0]                   i_host_byte_en,
    input  logic                         i_host_lock,
    output logic                         o_host_gnt,
    output logic                         o_host_rd_valid,
    output logic [31:0]                  o_host_rd_data,
    output logic                         o_host_err,
    output logic                         o_mem_en,
    output logic                         o_mem_wr_en,
    output logic [$clog2(MEM_DEPTH)-1:0] o_mem_addr,
    output logic [31:0]                  o_mem_wr_data,
    output logic [3:0]                   o_mem_byte_en,
    input  logic [31:0]                  i_mem_rd_data
);

    localparam int                    LP_AW    = $clog2(MEM_DEPTH);
    localparam int                    LP_CNT_W = $clog2(MAX_HOST_BURST + 1);
    localparam logic [LP_CNT_W-1:0]   LP_MAX   = LP_CNT_W'(MAX_HOST_BURST);

    t_arb_state          r_state;
    t_arb_owner          r_last_winner;
    logic [LP_CNT_W-1:0] r_burst_cnt;
    logic                r_rsp_valid;
    t_arb_owner          r_rsp_owner;
    logic                r_rsp_load;
    logic                r_rsp_err;

    logic [1:0]  w_rr_gnt;
    logic [1:0]  w_gnt;
    logic        w_lock_mode;
    logic        w_burst_full;
    logic        w_contest;
    t_mem_req    w_req;
    logic [31:0] w_off;
    logic        w_in_range;
    logic        w_mem_en;
    logic        w_core_rsp;
    logic        w_host_rsp;

    rvc_asap_mem_arb_rr u_rr (
        .i_req         ({i_host_req, i_core_req}),
        .i_last_winner (r_last_winner == HOST),
        .o_gnt         (w_rr_gnt)
    );

    assign w_lock_mode  = (r_state == LOCK) && i_host_lock;
    assign w_burst_full = (r_burst_cnt == LP_MAX);
    assign w_contest    = i_core_req && i_host_req;

    // While locked the host wins unless its burst is spent and the core waits.
    always_comb begin
        w_gnt = 2'b00;
        if (i_rst) begin
            w_gnt = 2'b00;
        end else if (w_lock_mode) begin
            if (i_host_req && !(w_burst_full && i_core_req)) begin
                w_gnt = 2'b10;
            end else if (i_core_req) begin
                w_gnt = 2'b01;
            end
        end else begin
            w_gnt = w_rr_gnt;
        end
    end

    always_comb begin
        if (w_gnt[1]) begin
            w_req = '{wr_en: i_host_wr_en, addr: 32'(i_host_addr),
                      wr_data: i_host_wr_data, byte_en: i_host_byte_en};
        end else begin
            w_req = '{wr_en: i_core_wr_en, addr: 32'(i_core_addr),
                      wr_data: i_core_wr_data, byte_en: i_core_byte_en};
        end
    end

    // Misaligned addresses fall out of range along with anything outside the window.
    assign w_off      = w_req.addr - MEM_BASE;
    assign w_in_range = (w_req.addr[1:0] == 2'b00) && (w_req.addr >= MEM_BASE) &&
                        ((w_off >> (LP_AW + 2)) == 32'd0);
    assign w_mem_en   = (|w_gnt) && w_in_range;

    assign o_core_gnt    = w_gnt[0];
    assign o_host_gnt    = w_gnt[1];
    assign o_core_stall  = i_core_req && !w_gnt[0] && !i_rst;
    assign o_mem_en      = w_mem_en;
    assign o_mem_wr_en   = w_mem_en && w_req.wr_en;
    assign o_mem_addr    = w_mem_en ? w_off[LP_AW+1:2] : '0;
    assign o_mem_wr_data = w_mem_en ? w_req.wr_data : 32'd0;
    assign o_mem_byte_en = w_mem_en ? w_req.byte_en : 4'd0;

    always_ff @(posedge i_clock) begin
        if (i_rst) begin
            r_state       <= ARB;
            r_last_winner <= HOST;
            r_burst_cnt   <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_owner   <= CORE;
            r_rsp_load    <= 1'b0;
            r_rsp_err     <= 1'b0;
        end else begin
            r_rsp_valid <= |w_gnt;
            r_rsp_owner <= w_gnt[1] ? HOST : CORE;
            r_rsp_load  <= !w_req.wr_en;
            r_rsp_err   <= !w_in_range;
            if (w_contest && (|w_gnt)) begin
                r_last_winner <= w_gnt[1] ? HOST : CORE;
            end
            if (w_lock_mode) begin
                if (w_gnt[1]) begin
                    r_burst_cnt <= w_burst_full ? LP_MAX : r_burst_cnt + 1'b1;
                end else if (w_gnt[0] && i_host_req) begin
                    r_burst_cnt <= '0;
                end
            end else if (w_gnt[1] && i_host_lock) begin
                r_state     <= LOCK;
                r_burst_cnt <= LP_CNT_W'(1);
            end else begin
                r_state     <= ARB;
                r_burst_cnt <= '0;
            end
        end
    end

    assign w_core_rsp      = r_rsp_valid && (r_rsp_owner == CORE) && !i_rst;
    assign w_host_rsp      = r_rsp_valid && (r_rsp_owner == HOST) && !i_rst;
    assign o_core_rd_valid = w_core_rsp && r_rsp_load;
    assign o_host_rd_valid = w_host_rsp && r_rsp_load;
    assign o_core_err      = w_core_rsp && r_rsp_err;
    assign o_host_err      = w_host_rsp && r_rsp_err;
    assign o_core_rd_data  = (o_core_rd_valid && !r_rsp_err) ? i_mem_rd_data : 32'd0;
    assign o_host_rd_data  = (o_host_rd_valid && !r_rsp_err) ? i_mem_rd_data : 32'd0;

endmodule

// File: tb/tb_rvc_asap_mem_arb.sv
// Directed bench for rvc_asap_mem_arb: reset, single-port access, contests,
// host burst lock, range errors, mid-flight reset and a pipelined mix.
module tb_rvc_asap_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_wr_en, host_req, host_wr_en, host_lock;
    logic [31:0] core_addr, core_wr_data, host_addr, host_wr_data;
    logic [3:0]  core_byte_en, host_byte_en;
    logic        core_gnt, core_stall, core_rd_valid, core_err;
    logic        host_gnt, host_rd_valid, host_err;
    logic [31:0] core_rd_data, host_rd_data;
    logic        mem_en, mem_wr_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wr_data, mem_rd_data;
    logic [3:0]  mem_byte_en;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Read data is a fixed pattern of the word index; it holds between reads.
    always @(posedge clk) begin
        if (mem_en && !mem_wr_en) mem_rd_data <= 32'hA500_0000 | 32'(mem_addr);
    end

    rvc_asap_mem_arb dut (
        .i_clock(clk), .i_rst(rst),
        .i_core_req(core_req), .i_core_wr_en(core_wr_en), .i_core_addr(core_addr),
        .i_core_wr_data(core_wr_data), .i_core_byte_en(core_byte_en),
        .o_core_gnt(core_gnt), .o_core_stall(core_stall), .o_core_rd_valid(core_rd_valid),
        .o_core_rd_data(core_rd_data), .o_core_err(core_err),
        .i_host_req(host_req), .i_host_wr_en(host_wr_en), .i_host_addr(host_addr),
        .i_host_wr_data(host_wr_data), .i_host_byte_en(host_byte_en), .i_host_lock(host_lock),
        .o_host_gnt(host_gnt), .o_host_rd_valid(host_rd_valid), .o_host_rd_data(host_rd_data),
        .o_host_err(host_err),
        .o_mem_en(mem_en), .o_mem_wr_en(mem_wr_en), .o_mem_addr(mem_addr),
        .o_mem_wr_data(mem_wr_data), .o_mem_byte_en(mem_byte_en), .i_mem_rd_data(mem_rd_data)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic set_core(input logic req, input logic wr, input logic [31:0] addr);
        core_req = req; core_wr_en = wr; core_addr = addr;
        core_wr_data = 32'hC0DE_0000 | addr; core_byte_en = 4'hF;
    endtask

    task automatic set_host(input logic req, input logic wr, input logic [31:0] addr, input logic lock);
        host_req = req; host_wr_en = wr; host_addr = addr; host_lock = lock;
        host_wr_data = 32'hD00D_0000 | addr; host_byte_en = 4'hF;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
        $display("txn t=%0t rst=%0b cgnt=%0b hgnt=%0b mem_en=%0b we=%0b maddr=%0d crv=%0b hrv=%0b cerr=%0b",
                 $time, rst, core_gnt, host_gnt, mem_en, mem_wr_en, mem_addr,
                 core_rd_valid, host_rd_valid, core_err);
    endtask

    initial begin
        logic [1:0] exp_gnt;
        mem_rd_data = 32'h0;
        rst = 1'b1;
        set_core(1'b1, 1'b0, 32'h1000);
        set_host(1'b1, 1'b0, 32'h1004, 1'b0);

        // Reset holds every output low even with both requesting.
        next_cycle(); next_cycle(); settle();
        check("rst_core_gnt", 32'(core_gnt), 32'd0);
        check("rst_host_gnt", 32'(host_gnt), 32'd0);
        check("rst_stall", 32'(core_stall), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_rd_valid", 32'({core_rd_valid, host_rd_valid}), 32'd0);

        // Core-only load at 0x1004.
        next_cycle(); rst = 1'b0;
        set_core(1'b1, 1'b0, 32'h1004); set_host(1'b0, 1'b0, 32'h0, 1'b0); settle();
        check("c1_core_gnt", 32'(core_gnt), 32'd1);
        check("c1_mem_en", 32'(mem_en), 32'd1);
        check("c1_mem_addr", 32'(mem_addr), 32'd1);
        check("c1_mem_wr_en", 32'(mem_wr_en), 32'd0);
        next_cycle(); set_core(1'b0, 1'b0, 32'h0); settle();
        check("c1_core_rv", 32'(core_rd_valid), 32'd1);
        check("c1_core_rd", core_rd_data, 32'hA500_0001);
        check("c1_host_rv", 32'(host_rd_valid), 32'd0);
        check("c1_host_rd", host_rd_data, 32'd0);

        // Contest: core, host, core with responses following each grant.
        next_cycle();
        set_core(1'b1, 1'b0, 32'h1008); set_host(1'b1, 1'b0, 32'h100C, 1'b0); settle();
        check("ct0_gnt", 32'({host_gnt, core_gnt}), 32'b01);
        check("ct0_stall", 32'(core_stall), 32'd0);
        next_cycle(); settle();
        check("ct1_gnt", 32'({host_gnt, core_gnt}), 32'b10);
        check("ct1_stall", 32'(core_stall), 32'd1);
        check("ct1_core_rd", core_rd_data, 32'hA500_0002);
        next_cycle(); settle();
        check("ct2_gnt", 32'({host_gnt, core_gnt}), 32'b01);
        check("ct2_host_rd", host_rd_data, 32'hA500_0003);
        check("ct2_core_rv", 32'(core_rd_valid), 32'd0);

        // Host burst lock: host alone first, then both contend for 17 cycles.
        for (int c = 0; c < 18; c++) begin
            next_cycle();
            set_host(1'b1, 1'b1, 32'h1000 + 32'(4 * c), 1'b1);
            set_core(c != 0, 1'b0, 32'h1010);
            settle();
            exp_gnt = (c == 8 || c == 17) ? 2'b01 : 2'b10;
            check($sformatf("burst%0d_gnt", c), 32'({host_gnt, core_gnt}), 32'(exp_gnt));
        end
        // Lock dropped: alternation resumes, host first since core won last.
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            set_host(1'b1, 1'b1, 32'h1040, 1'b0);
            settle();
            exp_gnt = (c % 2 == 0) ? 2'b10 : 2'b01;
            check($sformatf("unlock%0d_gnt", c), 32'({host_gnt, core_gnt}), 32'(exp_gnt));
        end

        // Out-of-range and misaligned accesses.
        next_cycle(); set_host(1'b0, 1'b0, 32'h0, 1'b0);
        set_core(1'b1, 1'b1, 32'h0000_0FFC); settle();
        check("oor_st_gnt", 32'(core_gnt), 32'd1);
        check("oor_st_mem_en", 32'(mem_en), 32'd0);
        next_cycle(); set_core(1'b1, 1'b0, 32'h2000); settle();
        check("oor_st_err", 32'(core_err), 32'd1);
        check("oor_st_rv", 32'(core_rd_valid), 32'd0);
        check("oor_ld_mem_en", 32'(mem_en), 32'd0);
        next_cycle(); set_core(1'b1, 1'b0, 32'h1002); settle();
        check("oor_ld_err", 32'(core_err), 32'd1);
        check("oor_ld_rv", 32'(core_rd_valid), 32'd1);
        check("oor_ld_rd", core_rd_data, 32'd0);
        next_cycle(); set_core(1'b0, 1'b0, 32'h0); settle();
        check("mis_ld_err", 32'(core_err), 32'd1);
        check("mis_ld_rv", 32'(core_rd_valid), 32'd1);

        // Reset while a host load is in flight.
        next_cycle(); set_host(1'b1, 1'b0, 32'h1010, 1'b0); settle();
        check("rmid_host_gnt", 32'(host_gnt), 32'd1);
        rst = 1'b1;
        next_cycle();
        set_core(1'b1, 1'b0, 32'h1000); set_host(1'b1, 1'b0, 32'h1004, 1'b0); settle();
        check("rmid_host_rv", 32'(host_rd_valid), 32'd0);
        check("rmid_gnt", 32'({host_gnt, core_gnt}), 32'd0);
        check("rmid_mem_en", 32'(mem_en), 32'd0);
        next_cycle(); rst = 1'b0; settle();
        check("rpost_gnt", 32'({host_gnt, core_gnt}), 32'b01);
        check("rpost_host_rv", 32'(host_rd_valid), 32'd0);

        // Pipelined mix: alternating single core / host loads every cycle.
        for (int c = 0; c < 7; c++) begin
            next_cycle();
            if (c < 6) begin
                set_core(c % 2 == 0, 1'b0, 32'h1000 + 32'(4 * (20 + c)));
                set_host(c % 2 == 1, 1'b0, 32'h1000 + 32'(4 * (20 + c)), 1'b0);
            end else begin
                set_core(1'b0, 1'b0, 32'h0); set_host(1'b0, 1'b0, 32'h0, 1'b0);
            end
            settle();
            if (c < 6) check($sformatf("mix%0d_gnt", c), 32'({host_gnt, core_gnt}),
                             (c % 2 == 0) ? 32'b01 : 32'b10);
            if (c > 0) begin
                check($sformatf("mix%0d_rv", c), 32'({host_rd_valid, core_rd_valid}),
                      (c % 2 == 1) ? 32'b01 : 32'b10);
                check($sformatf("mix%0d_rd", c), core_rd_data | host_rd_data,
                      32'hA500_0000 | 32'(20 + c - 1));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
